// File: rtl/psum_drain_pkg.sv
// Shared types, saturation constants and the saturating adder for the psum drain path.
package psum_drain_pkg;

    localparam int DEF_PSUM_W = 32;
    localparam int DEF_CNT_W  = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    localparam logic [DEF_PSUM_W-1:0] SAT_POS  = {1'b0, {(DEF_PSUM_W-1){1'b1}}};
    localparam logic [DEF_PSUM_W-1:0] SAT_NEG  = {1'b1, {(DEF_PSUM_W-1){1'b0}}};
    localparam logic [DEF_PSUM_W-1:0] SAT_UMAX = {DEF_PSUM_W{1'b1}};

    // Returns {saturated, clamped_sum}.
    function automatic logic [DEF_PSUM_W:0] sat_add(
        input logic [DEF_PSUM_W-1:0] a,
        input logic [DEF_PSUM_W-1:0] b,
        input logic                  is_signed
    );
        logic [DEF_PSUM_W:0] ext;
        logic                ovf;
        if (is_signed) begin
            ext = {a[DEF_PSUM_W-1], a} + {b[DEF_PSUM_W-1], b};
            ovf = (a[DEF_PSUM_W-1] == b[DEF_PSUM_W-1]) &&
                  (ext[DEF_PSUM_W-1] != a[DEF_PSUM_W-1]);
            if (ovf)
                return {1'b1, (a[DEF_PSUM_W-1] ? SAT_NEG : SAT_POS)};
            return {1'b0, ext[DEF_PSUM_W-1:0]};
        end
        ext = {1'b0, a} + {1'b0, b};
        if (ext[DEF_PSUM_W])
            return {1'b1, SAT_UMAX};
        return {1'b0, ext[DEF_PSUM_W-1:0]};
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small in-order FIFO with a registered head output that holds its last value when empty.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic                     valid,
    output logic [WIDTH-1:0]         data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic [WIDTH-1:0] data_reg;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && (count_reg != CW'(DEPTH));
    assign do_pop  = pop && (count_reg != '0);

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr_reg] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            data_reg   <= '0;
        end else begin
            if (do_push)
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (do_pop)
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            count_reg <= count_reg + CW'(do_push) - CW'(do_pop);
            // Head register tracks the entry that will be at rd_ptr next cycle.
            if (do_pop) begin
                if (count_reg > CW'(1))
                    data_reg <= mem[rd_ptr_reg + AW'(1)];
                else if (do_push)
                    data_reg <= push_data;
            end else if (do_push && count_reg == '0) begin
                data_reg <= push_data;
            end
        end
    end

    assign valid = (count_reg != '0);
    assign data  = data_reg;
    assign count = count_reg;

endmodule

// File: rtl/psum_drain.sv
// Column psum sink: accumulates groups of psums with saturation, shifts, optional ReLU, and queues results.
module psum_drain
    import psum_drain_pkg::*;
#(
    parameter int PSUM_W = DEF_PSUM_W,
    parameter int CNT_W  = DEF_CNT_W,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [CNT_W-1:0]  cfg_num_passes,
    input  logic [4:0]        cfg_shift,
    input  logic              cfg_signed,
    input  logic              cfg_relu,
    input  logic              psum_valid,
    output logic              psum_ready,
    input  logic [PSUM_W-1:0] psum_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PSUM_W-1:0] out_data,
    output logic              busy,
    output logic              sat_flag
);

    localparam int FCW = $clog2(DEPTH) + 1;

    state_t            state_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic [CNT_W-1:0]  passes_reg;
    logic [4:0]        shift_reg;
    logic              signed_reg;
    logic              relu_reg;
    logic [PSUM_W-1:0] acc_reg;
    logic              sat_reg;

    logic [FCW-1:0]    fifo_count;
    logic              accept;
    logic              take;
    logic              last;
    logic              push;
    logic              add_sat;
    logic [CNT_W-1:0]  eff_passes;
    logic [4:0]        eff_shift;
    logic              eff_signed;
    logic              eff_relu;
    logic [PSUM_W:0]   sum_ext;
    logic [PSUM_W-1:0] new_acc;
    logic [PSUM_W-1:0] shifted;
    logic [PSUM_W-1:0] res;

    assign psum_ready = !reset && (fifo_count < FCW'(DEPTH));
    assign accept     = psum_valid && psum_ready;
    assign take       = accept && !flush;

    // In IDLE the live config applies (it is being latched); in ACCUM the shadow copy does.
    always_comb begin
        eff_passes = passes_reg;
        eff_shift  = shift_reg;
        eff_signed = signed_reg;
        eff_relu   = relu_reg;
        if (state_reg == IDLE) begin
            eff_passes = (cfg_num_passes == '0) ? CNT_W'(1) : cfg_num_passes;
            eff_shift  = cfg_shift;
            eff_signed = cfg_signed;
            eff_relu   = cfg_relu;
        end
    end

    always_comb begin
        sum_ext = sat_add(acc_reg, psum_data, signed_reg);
        new_acc = psum_data;
        add_sat = 1'b0;
        last    = (eff_passes == CNT_W'(1));
        if (state_reg == ACCUM) begin
            new_acc = sum_ext[PSUM_W-1:0];
            add_sat = sum_ext[PSUM_W];
            last    = (({1'b0, cnt_reg} + (CNT_W+1)'(1)) == {1'b0, passes_reg});
        end
        if (eff_signed)
            shifted = $signed(new_acc) >>> eff_shift;
        else
            shifted = new_acc >> eff_shift;
        res  = (eff_relu && eff_signed && shifted[PSUM_W-1]) ? '0 : shifted;
        push = take && last;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            passes_reg <= '0;
            shift_reg  <= '0;
            signed_reg <= 1'b0;
            relu_reg   <= 1'b0;
            acc_reg    <= '0;
            sat_reg    <= 1'b0;
        end else if (flush) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            acc_reg   <= '0;
        end else if (take) begin
            if (state_reg == IDLE) begin
                passes_reg <= eff_passes;
                shift_reg  <= cfg_shift;
                signed_reg <= cfg_signed;
                relu_reg   <= cfg_relu;
                acc_reg    <= psum_data;
                cnt_reg    <= CNT_W'(1);
                state_reg  <= last ? IDLE : ACCUM;
            end else begin
                acc_reg <= new_acc;
                cnt_reg <= cnt_reg + CNT_W'(1);
                sat_reg <= sat_reg | add_sat;
                if (last)
                    state_reg <= IDLE;
            end
        end
    end

    sync_fifo #(
        .WIDTH (PSUM_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (res),
        .pop       (out_ready),
        .valid     (out_valid),
        .data      (out_data),
        .count     (fifo_count)
    );

    assign busy     = (state_reg == ACCUM) || (fifo_count != '0);
    assign sat_flag = sat_reg;

endmodule
